filter_tap_accumulator: RTL and testbench

// - Consumer side of the constant-multiplier block: accepts one signed tap product per handshake and accumulates NUM_TAPS products per sample.
// - Rounds, shifts and clips each finished sum to an unsigned pixel.
// - Sits between the product-select mux and the angular predictor output buffer.
// - Emits one predicted sample per NUM_TAPS accepted products.

---
 rtl/average4_pkg.sv | 14 +
 rtl/filter_tap_accumulator_round_clip_unit.sv | 32 +++
 rtl/filter_tap_accumulator.sv | 89 ++++++++
 tb/tb_filter_tap_accumulator.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/average4_pkg.sv
// Shared constants and types for the tap accumulator and its round/clip stage.
package average4_pkg;
  localparam int PROD_W    = 16;
  localparam int ACC_W     = 18;
  localparam int SAMPLE_W  = 8;
  localparam int SHIFT     = 6;
  localparam int NUM_TAPS  = 4;
  localparam int ROUND_OFS = 1 << (SHIFT - 1);
  localparam int CNT_W     = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;

  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic signed [ACC_W-1:0]  acc_t;
  typedef logic        [SAMPLE_W-1:0] sample_t;
endpackage

// File: rtl/filter_tap_accumulator_round_clip_unit.sv
// round_clip_unit: combinational round-half-up, arithmetic shift and clip of a finished tap sum.
module round_clip_unit
  import average4_pkg::*;
(
  input  logic [ACC_W-1:0]    sum,
  output logic [SAMPLE_W-1:0] sample,
  output logic                clipped
);
  // One guard bit so adding the rounding offset to the largest sum cannot wrap.
  typedef logic signed [ACC_W:0] wide_t;

  localparam wide_t MAX_W = wide_t'((1 << SAMPLE_W) - 1);

  function automatic wide_t round_shift(input acc_t s);
    wide_t biased;
    biased = wide_t'(s) + wide_t'(ROUND_OFS);
    return biased >>> SHIFT;
  endfunction

  function automatic logic [SAMPLE_W:0] saturate(input wide_t r);
    if (r[ACC_W])
      return {1'b1, {SAMPLE_W{1'b0}}};
    else if (r > MAX_W)
      return {1'b1, {SAMPLE_W{1'b1}}};
    else
      return {1'b0, r[SAMPLE_W-1:0]};
  endfunction

  always_comb begin
    {clipped, sample} = saturate(round_shift(acc_t'(sum)));
  end
endmodule

// File: rtl/filter_tap_accumulator.sv
// Accumulates NUM_TAPS signed products per sample and emits a rounded, clipped pixel.
// Optional o_clipped status port is enabled with the macro FTA_CLIP_STATUS_EN.
module filter_tap_accumulator
  import average4_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_clear,
  input  logic                p_valid,
  output logic                p_ready,
  input  logic [PROD_W-1:0]   p_data,
  output logic                o_valid,
  input  logic                o_ready,
  output logic [SAMPLE_W-1:0] o_sample
`ifdef FTA_CLIP_STATUS_EN
  ,
  output logic                o_clipped
`endif
);
  if (ACC_W < PROD_W + $clog2(NUM_TAPS)) begin : g_acc_w_check
    $error("ACC_W too narrow for NUM_TAPS products");
  end

  acc_t             acc;
  logic [CNT_W-1:0] tap_cnt;
  logic             last_tap;
  logic             accept;
  logic             complete;
  acc_t             ext;
  acc_t             sum;
  sample_t          rc_sample;

  assign last_tap = (tap_cnt == CNT_W'(NUM_TAPS - 1));
  // Only the completing tap waits on a stalled output; clear blocks all accepts.
  assign p_ready  = !i_clear && !(last_tap && o_valid && !o_ready);
  assign accept   = p_valid && p_ready;
  assign complete = accept && last_tap;
  assign ext      = acc_t'(prod_t'(p_data));
  assign sum      = (tap_cnt == '0) ? ext : acc + ext;

`ifdef FTA_CLIP_STATUS_EN
  logic rc_clipped;
`else
  logic rc_clipped_unused;
`endif

  round_clip_unit u_round_clip (
    .sum     (sum),
    .sample  (rc_sample),
`ifdef FTA_CLIP_STATUS_EN
    .clipped (rc_clipped)
`else
    .clipped (rc_clipped_unused)
`endif
  );

  // Accumulate stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc     <= '0;
      tap_cnt <= '0;
    end else if (i_clear) begin
      acc     <= '0;
      tap_cnt <= '0;
    end else if (accept) begin
      acc     <= sum;
      tap_cnt <= last_tap ? '0 : tap_cnt + 1'b1;
    end
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_valid   <= 1'b0;
      o_sample  <= '0;
`ifdef FTA_CLIP_STATUS_EN
      o_clipped <= 1'b0;
`endif
    end else if (complete) begin
      o_valid   <= 1'b1;
      o_sample  <= rc_sample;
`ifdef FTA_CLIP_STATUS_EN
      o_clipped <= rc_clipped;
`endif
    end else if (o_valid && o_ready) begin
      o_valid   <= 1'b0;
    end
  end
endmodule

// File: tb/tb_filter_tap_accumulator.sv
// Directed, table-driven bench for filter_tap_accumulator (o_clipped checked when FTA_CLIP_STATUS_EN is defined).
module tb_filter_tap_accumulator;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_clear;
  logic        p_valid;
  logic        p_ready;
  logic [15:0] p_data;
  logic        o_valid;
  logic        o_ready;
  logic [7:0]  o_sample;
`ifdef FTA_CLIP_STATUS_EN
  logic        o_clipped;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  filter_tap_accumulator dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (i_clear),
    .p_valid  (p_valid),
    .p_ready  (p_ready),
    .p_data   (p_data),
    .o_valid  (o_valid),
    .o_ready  (o_ready),
    .o_sample (o_sample)
`ifdef FTA_CLIP_STATUS_EN
    ,
    .o_clipped(o_clipped)
`endif
  );

  typedef struct {
    int    p0, p1, p2, p3;
    int    exp_sample;
    int    exp_clip;
    string name;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int v);
    p_valid = 1'b1;
    p_data  = 16'(v);
    step();
    p_valid = 1'b0;
  endtask

  task automatic feed_set(input int x);
    feed(-x); feed(15 * x); feed(51 * x); feed(-x);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{-100, 1500, 5100, -100, 100, 0, "x100"};
    vecs[1]  = '{-50, 750, 2550, -50, 50, 0, "x50"};
    vecs[2]  = '{5100, 5100, 5100, 5100, 255, 1, "sat_hi"};
    vecs[3]  = '{-500, -500, -500, -500, 0, 1, "sat_lo"};
    vecs[4]  = '{31, 0, 0, 0, 0, 0, "sum31"};
    vecs[5]  = '{0, 0, 32, 0, 1, 0, "sum32"};
    vecs[6]  = '{-32, 0, 0, 0, 0, 0, "sum_m32"};
    vecs[7]  = '{0, -33, 0, 0, 0, 1, "sum_m33"};
    vecs[8]  = '{16320, 0, 0, 0, 255, 0, "sum16320"};
    vecs[9]  = '{0, 0, 0, 16352, 255, 1, "sum16352"};
    vecs[10] = '{32767, 32767, 32767, 32767, 255, 1, "max_pos"};
    vecs[11] = '{-32768, -32768, -32768, -32768, 0, 1, "max_neg"};

    rst_n = 1'b0; i_clear = 1'b0; p_valid = 1'b1; p_data = 16'd123; o_ready = 1'b1;
    step(); step();
    chk("rst_o_valid", int'(o_valid), 0);
    chk("rst_o_sample", int'(o_sample), 0);
`ifdef FTA_CLIP_STATUS_EN
    chk("rst_o_clipped", int'(o_clipped), 0);
`endif
    rst_n = 1'b1; p_valid = 1'b0;
    step();
    chk("post_rst_o_valid", int'(o_valid), 0);

    for (int i = 0; i < 12; i++) begin
      chk({vecs[i].name, "_p_ready"}, int'(p_ready), 1);
      feed(vecs[i].p0); feed(vecs[i].p1); feed(vecs[i].p2);
      chk({vecs[i].name, "_no_early_valid"}, int'(o_valid), 0);
      feed(vecs[i].p3);
      chk({vecs[i].name, "_o_valid"}, int'(o_valid), 1);
      chk({vecs[i].name, "_o_sample"}, int'(o_sample), vecs[i].exp_sample);
`ifdef FTA_CLIP_STATUS_EN
      chk({vecs[i].name, "_o_clipped"}, int'(o_clipped), vecs[i].exp_clip);
`endif
    end
    step();
    chk("drain_o_valid", int'(o_valid), 0);

    // Backpressure: 8 products streamed with the output stalled
    o_ready = 1'b0;
    feed_set(100);
    chk("bp_first_valid", int'(o_valid), 1);
    chk("bp_first_sample", int'(o_sample), 100);
    feed(-50);
    chk("bp_hold5_sample", int'(o_sample), 100);
    feed(750);
    chk("bp_hold6_valid", int'(o_valid), 1);
    chk("bp_p_ready7", int'(p_ready), 1);
    feed(2550);
    chk("bp_hold7_sample", int'(o_sample), 100);
    p_valid = 1'b1; p_data = 16'(-50);
    #1;
    chk("bp_p_ready8_low", int'(p_ready), 0);
    step();
    chk("bp_still_low", int'(p_ready), 0);
    chk("bp_stall_sample", int'(o_sample), 100);
    chk("bp_stall_valid", int'(o_valid), 1);
    o_ready = 1'b1;
    #1;
    chk("bp_p_ready_rise", int'(p_ready), 1);
    step();
    p_valid = 1'b0;
    chk("bp_overlap_valid", int'(o_valid), 1);
    chk("bp_overlap_sample", int'(o_sample), 50);
    step();
    chk("bp_drain_valid", int'(o_valid), 0);

    // Clear while a sample is pending: the sample survives
    o_ready = 1'b0;
    feed_set(100);
    i_clear = 1'b1; p_valid = 1'b1; p_data = 16'd999;
    #1;
    chk("clr_pend_p_ready", int'(p_ready), 0);
    step();
    i_clear = 1'b0; p_valid = 1'b0;
    chk("clr_pend_valid", int'(o_valid), 1);
    chk("clr_pend_sample", int'(o_sample), 100);
    o_ready = 1'b1;
    step();
    chk("clr_pend_drain", int'(o_valid), 0);

    // Clear after two taps discards the partial sum
    feed(5000); feed(5000);
    i_clear = 1'b1; p_valid = 1'b1; p_data = 16'd7;
    #1;
    chk("clr2_p_ready", int'(p_ready), 0);
    step();
    i_clear = 1'b0; p_valid = 1'b0;
    feed_set(50);
    chk("clr2_valid", int'(o_valid), 1);
    chk("clr2_sample", int'(o_sample), 50);

    // Clear on the completing tap: no sample, counter restarts
    feed(-100); feed(1500); feed(5100);
    i_clear = 1'b1; p_valid = 1'b1; p_data = 16'(-100);
    step();
    i_clear = 1'b0; p_valid = 1'b0;
    chk("clr4_no_valid", int'(o_valid), 0);
    step();
    chk("clr4_no_valid2", int'(o_valid), 0);
    feed(-50); feed(750); feed(2550);
    chk("clr4_cnt_restart", int'(o_valid), 0);
    feed(-50);
    chk("clr4_after_valid", int'(o_valid), 1);
    chk("clr4_after_sample", int'(o_sample), 50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
